// File: rtl/leds_controller.sv
// rtl/leds_controller.sv - memory-mapped LED pattern sequencer (static/blink/rotate/bounce)
module leds_controller #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  data_m_addr,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic [15:0] leds_val
);

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    logic [15:0] value_q, value_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] period_q, period_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic [15:0] pattern_q, pattern_d;
    logic        phase_q, phase_d;
    logic [3:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [15:0] leds_q, leds_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;

    logic        access;
    logic        wr;
    logic        wr_value;
    logic        wr_ctrl;
    logic        wr_period;
    logic        mode_change;
    logic        restart;
    logic        run;
    logic        tick;

    function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                                input logic [15:0] new_val,
                                                input logic [1:0]  bytesel);
        logic [15:0] r;
        r = old_val;
        if (bytesel[1]) r[15:8] = new_val[15:8];
        if (bytesel[0]) r[7:0]  = new_val[7:0];
        return r;
    endfunction

    always_comb begin
        access    = cs & data_m_access;
        wr        = access & data_m_wr_en;
        wr_value  = wr & (data_m_addr == ADDR_VALUE) & (|data_m_bytesel);
        wr_ctrl   = wr & (data_m_addr == ADDR_CTRL) & data_m_bytesel[0];
        wr_period = wr & (data_m_addr == ADDR_PERIOD) & (|data_m_bytesel);

        value_d  = wr_value ? merge_bytes(value_q, data_m_data_in, data_m_bytesel) : value_q;
        ctrl_d   = wr_ctrl ? data_m_data_in[2:0] : ctrl_q;
        period_d = wr_period ? merge_bytes(period_q, data_m_data_in, data_m_bytesel) : period_q;

        mode_change = wr_ctrl & (data_m_data_in[1:0] != ctrl_q[1:0]);
        restart     = wr_value | mode_change;
        run         = ctrl_q[2];
        // A tick landing on a restart or PERIOD write is dropped, not deferred.
        tick        = run & (presc_q == 16'd0) & ~restart & ~wr_period;
    end

    always_comb begin
        presc_d = presc_q;
        if (wr_period) begin
            presc_d = period_d;
        end else if (restart) begin
            presc_d = period_q;
        end else if (run) begin
            presc_d = (presc_q == 16'd0) ? period_q : presc_q - 16'd1;
        end
        tick_count_d = tick ? tick_count_q + 16'd1 : tick_count_q;
    end

    always_comb begin
        pattern_d = pattern_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        if (restart) begin
            pattern_d = value_d;
            phase_d   = 1'b1;
            pos_d     = 4'd0;
            dir_d     = 1'b0;
        end else if (tick) begin
            case (ctrl_q[1:0])
                MODE_BLINK:  phase_d   = ~phase_q;
                MODE_ROTATE: pattern_d = {pattern_q[14:0], pattern_q[15]};
                MODE_BOUNCE: begin
                    // dir_q=0 walks up; endpoints reflect so neither is shown twice.
                    if (!dir_q) begin
                        if (pos_q == 4'd15) begin
                            dir_d = 1'b1;
                            pos_d = 4'd14;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        if (pos_q == 4'd0) begin
                            dir_d = 1'b0;
                            pos_d = 4'd1;
                        end else begin
                            pos_d = pos_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        leds_d = value_q;
        case (ctrl_q[1:0])
            MODE_STATIC: leds_d = value_q;
            MODE_BLINK:  leds_d = phase_q ? value_q : 16'h0000;
            MODE_ROTATE: leds_d = pattern_q;
            MODE_BOUNCE: leds_d = 16'h0001 << pos_q;
            default:     leds_d = value_q;
        endcase
    end

    always_comb begin
        rdata_d = 16'h0000;
        if (access) begin
            case (data_m_addr)
                ADDR_VALUE:  rdata_d = value_q;
                ADDR_CTRL:   rdata_d = {13'd0, ctrl_q};
                ADDR_PERIOD: rdata_d = period_q;
                ADDR_STATUS: rdata_d = tick_count_q;
                default:     rdata_d = 16'h0000;
            endcase
        end
        ack_d = access;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= 16'h0000;
            ctrl_q       <= 3'd0;
            period_q     <= DEFAULT_PERIOD;
            presc_q      <= DEFAULT_PERIOD;
            tick_count_q <= 16'h0000;
            pattern_q    <= 16'h0000;
            phase_q      <= 1'b1;
            pos_q        <= 4'd0;
            dir_q        <= 1'b0;
            leds_q       <= 16'h0000;
            rdata_q      <= 16'h0000;
            ack_q        <= 1'b0;
        end else begin
            value_q      <= value_d;
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            presc_q      <= presc_d;
            tick_count_q <= tick_count_d;
            pattern_q    <= pattern_d;
            phase_q      <= phase_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            leds_q       <= leds_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
        end
    end

    assign leds_val        = leds_q;
    assign data_m_data_out = rdata_q;
    assign data_m_ack      = ack_q;

endmodule

// File: tb/tb_leds_controller.sv
// tb/tb_leds_controller.sv - scoreboard bench for leds_controller
module tb_leds_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [1:0]  data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_ack;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic [15:0] leds_val;

    leds_controller dut (
        .clk             (clk),
        .reset           (reset),
        .cs              (cs),
        .data_m_addr     (data_m_addr),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_access   (data_m_access),
        .data_m_ack      (data_m_ack),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_bytesel  (data_m_bytesel),
        .leds_val        (leds_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          chk_data;
        int          cyc;
        string       name;
    } acc_t;

    acc_t        acc_q[$];
    logic [15:0] leds_exp[$];
    logic [15:0] last_leds = 16'h0000;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bus response monitor: every ack must match the oldest outstanding access.
    always @(negedge clk) begin
        if (data_m_ack === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("ack_unexpected", acc_q.size(), 1);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                chk({e.name, "_ack_cycle"}, cyc, e.cyc);
                if (e.chk_data) chk(e.name, data_m_data_out, e.data);
            end
        end
    end

    // LED monitor: every change of leds_val must be the next expected value.
    always @(negedge clk) begin
        if (leds_val !== last_leds) begin
            if (leds_exp.size() == 0) chk("leds_unexpected", leds_val, last_leds);
            else chk("leds_seq", leds_val, leds_exp.pop_front());
            last_leds = leds_val;
        end
    end

    task automatic bus(input bit wr, input logic [1:0] a, input logic [15:0] d,
                       input logic [1:0] bs, input logic [15:0] exp, input string name);
        acc_t e;
        e.data = exp;
        e.chk_data = !wr;
        e.cyc = cyc + 1;
        e.name = name;
        acc_q.push_back(e);
        cs = 1'b1;
        data_m_access = 1'b1;
        data_m_wr_en = wr;
        data_m_addr = a;
        data_m_data_in = d;
        data_m_bytesel = bs;
        @(posedge clk);
        #1;
        cs = 1'b0;
        data_m_access = 1'b0;
        data_m_wr_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cs = 1'b0;
        data_m_access = 1'b0;
        data_m_wr_en = 1'b0;
        data_m_addr = 2'd0;
        data_m_data_in = 16'h0000;
        data_m_bytesel = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_leds", leds_val, 16'h0000);
        chk("rst_ack", data_m_ack, 1'b0);
        chk("rst_rdata", data_m_data_out, 16'h0000);

        bus(0, 2'd0, 16'h0, 2'b11, 16'h0000, "rst_value");
        bus(0, 2'd1, 16'h0, 2'b11, 16'h0000, "rst_ctrl");
        bus(0, 2'd2, 16'h0, 2'b11, 16'd49999, "rst_period");
        bus(0, 2'd3, 16'h0, 2'b11, 16'h0000, "rst_status");

        // Byte-lane writes in STATIC mode.
        leds_exp.push_back(16'hA500);
        leds_exp.push_back(16'hA534);
        bus(1, 2'd0, 16'hA5C3, 2'b10, 16'h0, "wr_value_hi");
        bus(1, 2'd0, 16'h1234, 2'b01, 16'h0, "wr_value_lo");
        bus(1, 2'd0, 16'hFFFF, 2'b00, 16'h0, "wr_value_none");
        bus(0, 2'd0, 16'h0, 2'b11, 16'hA534, "rd_value_bytes");
        bus(1, 2'd3, 16'h1234, 2'b11, 16'h0, "wr_status");
        bus(0, 2'd3, 16'h0, 2'b11, 16'h0000, "rd_status_ro");

        // ROTATE with PERIOD=3: a step every 4 clocks.
        bus(1, 2'd2, 16'd3, 2'b11, 16'h0, "wr_period3");
        leds_exp.push_back(16'h8001);
        leds_exp.push_back(16'h0003);
        leds_exp.push_back(16'h0006);
        leds_exp.push_back(16'h000C);
        bus(1, 2'd0, 16'h8001, 2'b11, 16'h0, "wr_value_rot");
        bus(1, 2'd1, 16'h0006, 2'b11, 16'h0, "wr_ctrl_rot");
        wait_cycles(12);
        bus(0, 2'd3, 16'h0, 2'b11, 16'd3, "rd_status_rot");
        bus(1, 2'd1, 16'h0002, 2'b11, 16'h0, "wr_ctrl_rot_stop");
        bus(0, 2'd3, 16'h0, 2'b11, 16'd3, "rd_status_rot_stop");

        // BOUNCE with PERIOD=0: one step per clock, 30-tick round trip.
        bus(1, 2'd2, 16'd0, 2'b11, 16'h0, "wr_period0");
        for (int t = 0; t <= 32; t++) begin
            int m;
            int p;
            m = t % 30;
            p = (m > 15) ? 30 - m : m;
            leds_exp.push_back(16'h0001 << p);
        end
        bus(1, 2'd1, 16'h0007, 2'b11, 16'h0, "wr_ctrl_bounce");
        wait_cycles(31);
        bus(1, 2'd1, 16'hFFFB, 2'b11, 16'h0, "wr_ctrl_bounce_stop");
        bus(0, 2'd3, 16'h0, 2'b11, 16'd35, "rd_status_bounce");
        bus(0, 2'd1, 16'h0, 2'b11, 16'h0003, "rd_ctrl_mask");

        // BLINK with PERIOD=1, then stop and confirm the freeze.
        bus(1, 2'd2, 16'd1, 2'b11, 16'h0, "wr_period1");
        leds_exp.push_back(16'h0001);
        leds_exp.push_back(16'h00FF);
        leds_exp.push_back(16'h0000);
        leds_exp.push_back(16'h00FF);
        bus(1, 2'd0, 16'h00FF, 2'b11, 16'h0, "wr_value_blink");
        bus(1, 2'd1, 16'h0005, 2'b11, 16'h0, "wr_ctrl_blink");
        wait_cycles(4);
        bus(1, 2'd1, 16'h0001, 2'b11, 16'h0, "wr_ctrl_blink_stop");
        bus(0, 2'd3, 16'h0, 2'b11, 16'd37, "rd_status_blink");
        wait_cycles(10);
        bus(0, 2'd3, 16'h0, 2'b11, 16'd37, "rd_status_frozen");
        bus(0, 2'd2, 16'h0, 2'b11, 16'd1, "rd_period1");

        // Resume, VALUE write on a tick edge, then reset mid-pattern.
        leds_exp.push_back(16'h0000);
        leds_exp.push_back(16'h00FF);
        leds_exp.push_back(16'h0F0F);
        leds_exp.push_back(16'h0000);
        leds_exp.push_back(16'h0F0F);
        leds_exp.push_back(16'h0000);
        bus(1, 2'd1, 16'h0005, 2'b11, 16'h0, "wr_ctrl_resume");
        wait_cycles(4);
        bus(1, 2'd0, 16'h0F0F, 2'b11, 16'h0, "wr_value_on_tick");
        wait_cycles(5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_leds", leds_val, 16'h0000);
        chk("mid_rst_ack", data_m_ack, 1'b0);
        chk("mid_rst_rdata", data_m_data_out, 16'h0000);
        bus(0, 2'd0, 16'h0, 2'b11, 16'h0000, "mid_rst_value");
        bus(0, 2'd1, 16'h0, 2'b11, 16'h0000, "mid_rst_ctrl");
        bus(0, 2'd2, 16'h0, 2'b11, 16'd49999, "mid_rst_period");
        bus(0, 2'd3, 16'h0, 2'b11, 16'h0000, "mid_rst_status");

        wait_cycles(5);
        chk("acc_queue_drained", acc_q.size(), 0);
        chk("leds_queue_drained", leds_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
